score_keeper: RTL and testbench

- Downstream consumer of the button judgement stage in the LED-matrix rhythm game.
- Samples the judgement code and hit strobe, plus a miss strobe from the note shifter.
- Maintains total score, combo, max combo and per-judgement tallies.
- Drives a timed judgement flash and a sequentially converted 4-digit BCD score for the display.

---
 rtl/score_keeper_pkg.sv | 29 ++
 rtl/score_keeper_bin2bcd_seq.sv | 85 ++++++++
 rtl/score_keeper.sv | 140 ++++++++++++++
 tb/tb_score_keeper.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/score_keeper_pkg.sv
// rtl/score_keeper_pkg.sv - shared constants, BCD converter state type and helpers
// Contents:
//   SCORE_W, CNT_W, BCD_W : datapath widths
//   JUDGE_*               : judgement codes produced by the judge stage
//   bcd_state_t           : sequential binary-to-BCD converter states
//   sat_inc               : saturating increment for 8-bit tallies
package score_keeper_pkg;

  localparam int SCORE_W = 14;
  localparam int CNT_W   = 8;
  localparam int BCD_W   = 16;

  localparam logic [1:0] JUDGE_NONE    = 2'b00;
  localparam logic [1:0] JUDGE_EARLY   = 2'b01;
  localparam logic [1:0] JUDGE_LATE    = 2'b10;
  localparam logic [1:0] JUDGE_PERFECT = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } bcd_state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/score_keeper_bin2bcd_seq.sv
// rtl/score_keeper_bin2bcd_seq.sv - sequential double-dabble binary to 4-digit BCD converter
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous abort to IDLE, zeroes bcd
//   start      : conversion request, accepted in IDLE or DONE
//   bin        : 14-bit value captured when start is accepted
//   bcd        : last completed result, updated only in DONE
//   busy       : high in LOAD, SHIFT and DONE
//   done       : high in DONE (result being written)
module bin2bcd_seq
  import score_keeper_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               start,
  input  logic [SCORE_W-1:0] bin,
  output logic [BCD_W-1:0]   bcd,
  output logic               busy,
  output logic               done
);

  localparam logic [3:0] LAST_SHIFT = 4'(SCORE_W - 1);

  bcd_state_t         state_q, state_d;
  logic [SCORE_W-1:0] sh_q;
  logic [BCD_W-1:0]   acc_q;
  logic [BCD_W-1:0]   adj;
  logic [3:0]         cnt_q;
  logic               take;

  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] a);
    logic [BCD_W-1:0] r;
    r = a;
    for (int i = 0; i < 4; i++) begin
      if (a[4*i +: 4] >= 4'd5) r[4*i +: 4] = a[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign adj  = dabble_adjust(acc_q);
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  // DONE may chain straight into the next conversion, so it accepts too
  assign take = start && !clear && ((state_q == IDLE) || (state_q == DONE));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    state_d = SHIFT;
      SHIFT:   if (cnt_q == LAST_SHIFT) state_d = DONE;
      DONE:    state_d = start ? LOAD : IDLE;
      default: state_d = IDLE;
    endcase
    if (clear) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bcd     <= '0;
    end else begin
      state_q <= state_d;
      if (clear) begin
        bcd <= '0;
      end else begin
        if (state_q == DONE) bcd <= acc_q;
        if (take) begin
          sh_q  <= bin;
          acc_q <= '0;
          cnt_q <= '0;
        end else if (state_q == SHIFT) begin
          acc_q <= {adj[BCD_W-2:0], sh_q[SCORE_W-1]};
          sh_q  <= {sh_q[SCORE_W-2:0], 1'b0};
          cnt_q <= cnt_q + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - rhythm game scoring: points, combo, tallies, judgement flash, BCD score
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   game_start      : pulse, clears all game state (events in that cycle ignored)
//   delete_note     : hit strobe, score valid in the same cycle
//   score           : judgement code (11 perfect, 10 late, 01 early, 00 none = miss)
//   note_miss       : pulse, note left the window unplayed
//   total_score     : saturating point total
//   combo/max_combo : current and best consecutive-hit count
//   *_cnt           : saturating per-judgement tallies
//   judge_code      : last judgement shown (00 for a miss)
//   flash_on        : judgement flash, lit FLASH_CYCLES cycles after the last event
//   score_bcd       : four BCD digits of total_score, MSD in [15:12]
//   bcd_busy        : BCD conversion in progress
module score_keeper
  import score_keeper_pkg::*;
#(
  parameter int PERFECT_PTS  = 3,
  parameter int OFFBEAT_PTS  = 1,
  parameter int COMBO_STEP   = 10,
  parameter int MAX_MULT     = 4,
  parameter int MAX_SCORE    = 9999,
  parameter int FLASH_CYCLES = 5000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               game_start,
  input  logic               delete_note,
  input  logic [1:0]         score,
  input  logic               note_miss,
  output logic [SCORE_W-1:0] total_score,
  output logic [CNT_W-1:0]   combo,
  output logic [CNT_W-1:0]   max_combo,
  output logic [CNT_W-1:0]   perfect_cnt,
  output logic [CNT_W-1:0]   late_cnt,
  output logic [CNT_W-1:0]   early_cnt,
  output logic [CNT_W-1:0]   miss_cnt,
  output logic [1:0]         judge_code,
  output logic               flash_on,
  output logic [BCD_W-1:0]   score_bcd,
  output logic               bcd_busy
);

  localparam int FLASH_W = $clog2(FLASH_CYCLES + 1);

  logic               hit, miss, evt;
  logic [CNT_W-1:0]   combo_hit;
  logic [SCORE_W-1:0] total_next;
  logic [FLASH_W-1:0] flash_cnt;
  logic               change, pending, conv_start, conv_done, accepted;
  int                 mult, pts, sum;

  assign hit       = delete_note && (score != JUDGE_NONE);
  assign miss      = (delete_note && (score == JUDGE_NONE)) || note_miss;
  assign evt       = delete_note || note_miss;
  assign combo_hit = sat_inc(combo);

  // Multiplier is taken from the combo before this hit is counted
  always_comb begin
    mult = 1 + int'(combo) / COMBO_STEP;
    if (mult > MAX_MULT) mult = MAX_MULT;
    pts  = ((score == JUDGE_PERFECT) ? PERFECT_PTS : OFFBEAT_PTS) * mult;
    sum  = int'(total_score) + pts;
    total_next = total_score;
    if (game_start) total_next = '0;
    else if (hit)   total_next = (sum > MAX_SCORE) ? SCORE_W'(MAX_SCORE) : SCORE_W'(sum);
  end

  // The converter samples total_next so an accepted request always gets the newest total
  assign change     = !game_start && (total_next != total_score);
  assign conv_start = change || pending;
  assign accepted   = conv_start && (!bcd_busy || conv_done);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_score <= '0;
      combo       <= '0;
      max_combo   <= '0;
      perfect_cnt <= '0;
      late_cnt    <= '0;
      early_cnt   <= '0;
      miss_cnt    <= '0;
      judge_code  <= JUDGE_NONE;
      flash_cnt   <= '0;
      flash_on    <= 1'b0;
      pending     <= 1'b0;
    end else if (game_start) begin
      total_score <= '0;
      combo       <= '0;
      max_combo   <= '0;
      perfect_cnt <= '0;
      late_cnt    <= '0;
      early_cnt   <= '0;
      miss_cnt    <= '0;
      judge_code  <= JUDGE_NONE;
      flash_cnt   <= '0;
      flash_on    <= 1'b0;
      pending     <= 1'b0;
    end else begin
      total_score <= total_next;
      pending     <= (pending || change) && !accepted;

      if (hit) begin
        // A coincident note_miss still breaks the combo, but the hit counts toward max_combo
        combo     <= miss ? '0 : combo_hit;
        max_combo <= (combo_hit > max_combo) ? combo_hit : max_combo;
        case (score)
          JUDGE_PERFECT: perfect_cnt <= sat_inc(perfect_cnt);
          JUDGE_LATE:    late_cnt    <= sat_inc(late_cnt);
          default:       early_cnt   <= sat_inc(early_cnt);
        endcase
      end else if (miss) begin
        combo <= '0;
      end
      if (miss) miss_cnt <= sat_inc(miss_cnt);

      // flash_on is lit from the edge after the event for exactly FLASH_CYCLES cycles
      if (evt) begin
        judge_code <= hit ? score : JUDGE_NONE;
        flash_cnt  <= FLASH_W'(FLASH_CYCLES - 1);
        flash_on   <= 1'b1;
      end else begin
        flash_on <= (flash_cnt != '0);
        if (flash_cnt != '0) flash_cnt <= flash_cnt - 1'b1;
      end
    end
  end

  bin2bcd_seq u_bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (game_start),
    .start (conv_start),
    .bin   (total_next),
    .bcd   (score_bcd),
    .busy  (bcd_busy),
    .done  (conv_done)
  );

endmodule

// File: tb/tb_score_keeper.sv
// tb/tb_score_keeper.sv - self-checking bench for score_keeper
module tb_score_keeper;

  localparam int FLASH = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        game_start, delete_note, note_miss;
  logic [1:0]  score;
  logic [13:0] total_score;
  logic [7:0]  combo, max_combo, perfect_cnt, late_cnt, early_cnt, miss_cnt;
  logic [1:0]  judge_code;
  logic        flash_on, bcd_busy;
  logic [15:0] score_bcd;

  score_keeper #(.FLASH_CYCLES(FLASH)) dut (
    .clk(clk), .rst_n(rst_n), .game_start(game_start), .delete_note(delete_note),
    .score(score), .note_miss(note_miss), .total_score(total_score), .combo(combo),
    .max_combo(max_combo), .perfect_cnt(perfect_cnt), .late_cnt(late_cnt),
    .early_cnt(early_cnt), .miss_cnt(miss_cnt), .judge_code(judge_code),
    .flash_on(flash_on), .score_bcd(score_bcd), .bcd_busy(bcd_busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int m_total, m_combo, m_max, m_pc, m_lc, m_ec, m_mc, m_judge;
  int edge_no = 0;
  int last_ev = -1;
  bit seen[0:9999];

  typedef struct {
    bit dn; bit [1:0] sc; bit nm; bit gs;
    int total; int combo; int maxc; int pc; int lc; int ec; int mc; int judge;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic int to_bcd(input int v);
    return ((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + v % 10;
  endfunction

  function automatic int sat255(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic model_clear();
    m_total = 0; m_combo = 0; m_max = 0; m_pc = 0; m_lc = 0; m_ec = 0; m_mc = 0; m_judge = 0;
    last_ev = -1;
    foreach (seen[i]) seen[i] = 1'b0;
    seen[0] = 1'b1;
  endtask

  task automatic model_step(input bit dn, input bit [1:0] sc, input bit nm, input bit gs);
    bit hit, miss;
    int mult;
    if (gs) begin
      model_clear();
      return;
    end
    hit  = dn && (sc != 2'b00);
    miss = (dn && (sc == 2'b00)) || nm;
    if (hit) begin
      mult = 1 + m_combo / 10;
      if (mult > 4) mult = 4;
      m_total = m_total + ((sc == 2'b11) ? 3 : 1) * mult;
      if (m_total > 9999) m_total = 9999;
      seen[m_total] = 1'b1;
      m_combo = sat255(m_combo + 1);
      if (m_combo > m_max) m_max = m_combo;
      if (sc == 2'b11) m_pc = sat255(m_pc + 1);
      else if (sc == 2'b10) m_lc = sat255(m_lc + 1);
      else m_ec = sat255(m_ec + 1);
    end
    if (miss) begin
      m_combo = 0;
      m_mc = sat255(m_mc + 1);
    end
    if (dn || nm) begin
      m_judge = hit ? int'(sc) : 0;
      last_ev = edge_no;
    end
  endtask

  task automatic check_all();
    int d3, d2, d1, d0;
    bit ok;
    chk("total", total_score, m_total);
    chk("combo", combo, m_combo);
    chk("max_combo", max_combo, m_max);
    chk("perfect_cnt", perfect_cnt, m_pc);
    chk("late_cnt", late_cnt, m_lc);
    chk("early_cnt", early_cnt, m_ec);
    chk("miss_cnt", miss_cnt, m_mc);
    chk("judge_code", judge_code, m_judge);
    chk("flash_on", flash_on, int'(last_ev >= 0 && (edge_no - last_ev) < FLASH));
    d3 = score_bcd[15:12]; d2 = score_bcd[11:8]; d1 = score_bcd[7:4]; d0 = score_bcd[3:0];
    ok = (d3 < 10) && (d2 < 10) && (d1 < 10) && (d0 < 10);
    if (ok) ok = seen[d3 * 1000 + d2 * 100 + d1 * 10 + d0];
    chk("bcd_untorn", int'(ok), 1);
  endtask

  task automatic step(input bit dn, input bit [1:0] sc, input bit nm, input bit gs);
    delete_note = dn; score = sc; note_miss = nm; game_start = gs;
    @(posedge clk);
    edge_no++;
    model_step(dn, sc, nm, gs);
    #1;
    delete_note = 1'b0; score = 2'b00; note_miss = 1'b0; game_start = 1'b0;
    check_all();
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && bcd_busy; i++) step(0, 2'b00, 0, 0);
    chk("settle_busy", bcd_busy, 0);
    chk("settle_bcd", score_bcd, to_bcd(m_total));
  endtask

  initial begin
    rst_n = 1'b0; game_start = 1'b0; delete_note = 1'b0; note_miss = 1'b0; score = 2'b00;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_total", total_score, 0);
    chk("rst_combo", combo, 0);
    chk("rst_max", max_combo, 0);
    chk("rst_miss", miss_cnt, 0);
    chk("rst_judge", judge_code, 0);
    chk("rst_flash", flash_on, 0);
    chk("rst_bcd", score_bcd, 0);
    chk("rst_busy", bcd_busy, 0);
    rst_n = 1'b1;

    // table: perfect run, miss, late, earlies, hit+miss, code-00 miss, game_start with hit
    vecs.push_back('{0, 2'b00, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{1, 2'b11, 0, 0,  3, 1, 1, 1, 0, 0, 0, 3});
    vecs.push_back('{1, 2'b11, 0, 0,  6, 2, 2, 2, 0, 0, 0, 3});
    vecs.push_back('{1, 2'b11, 0, 0,  9, 3, 3, 3, 0, 0, 0, 3});
    vecs.push_back('{1, 2'b11, 0, 0, 12, 4, 4, 4, 0, 0, 0, 3});
    vecs.push_back('{1, 2'b11, 0, 0, 15, 5, 5, 5, 0, 0, 0, 3});
    vecs.push_back('{0, 2'b00, 1, 0, 15, 0, 5, 5, 0, 0, 1, 0});
    vecs.push_back('{1, 2'b10, 0, 0, 16, 1, 5, 5, 1, 0, 1, 2});
    vecs.push_back('{1, 2'b01, 0, 0, 17, 2, 5, 5, 1, 1, 1, 1});
    vecs.push_back('{1, 2'b01, 0, 0, 18, 3, 5, 5, 1, 2, 1, 1});
    vecs.push_back('{1, 2'b01, 0, 0, 19, 4, 5, 5, 1, 3, 1, 1});
    vecs.push_back('{1, 2'b01, 0, 0, 20, 5, 5, 5, 1, 4, 1, 1});
    vecs.push_back('{1, 2'b01, 0, 0, 21, 6, 6, 5, 1, 5, 1, 1});
    vecs.push_back('{1, 2'b01, 0, 0, 22, 7, 7, 5, 1, 6, 1, 1});
    vecs.push_back('{1, 2'b01, 1, 0, 23, 0, 8, 5, 1, 7, 2, 1});
    vecs.push_back('{1, 2'b00, 0, 0, 23, 0, 8, 5, 1, 7, 3, 0});
    vecs.push_back('{1, 2'b11, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0});
    foreach (vecs[i]) begin
      step(vecs[i].dn, vecs[i].sc, vecs[i].nm, vecs[i].gs);
      chk($sformatf("vec%0d_total", i), total_score, vecs[i].total);
      chk($sformatf("vec%0d_combo", i), combo, vecs[i].combo);
      chk($sformatf("vec%0d_max", i), max_combo, vecs[i].maxc);
      chk($sformatf("vec%0d_pc", i), perfect_cnt, vecs[i].pc);
      chk($sformatf("vec%0d_lc", i), late_cnt, vecs[i].lc);
      chk($sformatf("vec%0d_ec", i), early_cnt, vecs[i].ec);
      chk($sformatf("vec%0d_mc", i), miss_cnt, vecs[i].mc);
      chk($sformatf("vec%0d_judge", i), judge_code, vecs[i].judge);
    end
    repeat (FLASH + 2) step(0, 2'b00, 0, 0);

    // isolated change: LOAD + 14 SHIFT + DONE = 16 cycles to score_bcd
    step(1, 2'b11, 0, 0);
    for (int k = 1; k <= 16; k++) begin
      step(0, 2'b00, 0, 0);
      chk("iso_busy", bcd_busy, int'(k < 16));
      if (k == 15) chk("iso_bcd_old", score_bcd, 16'h0000);
      if (k == 16) chk("iso_bcd_new", score_bcd, 16'h0003);
    end

    // flash restart: second event 5 cycles after the first, then falls FLASH cycles later
    step(1, 2'b10, 0, 0);
    repeat (4) step(0, 2'b00, 0, 0);
    step(1, 2'b01, 0, 0);
    for (int k = 1; k <= FLASH; k++) begin
      step(0, 2'b00, 0, 0);
      chk("flash_tail", flash_on, int'(k < FLASH));
    end

    // three perfects from a fresh game
    step(0, 2'b00, 0, 1);
    repeat (3) step(1, 2'b11, 0, 0);
    chk("p3_total", total_score, 9);
    chk("p3_combo", combo, 3);
    wait_idle(40);
    chk("p3_bcd", score_bcd, 16'h0009);

    // multiplier steps
    step(0, 2'b00, 0, 1);
    for (int i = 1; i <= 40; i++) begin
      step(1, 2'b11, 0, 0);
      if (i == 11) chk("mult2_total", total_score, 36);
      if (i == 40) chk("mult4_total", total_score, 300);
    end

    // climb to 9998 at mult 4, then saturate
    step(0, 2'b00, 0, 1);
    step(1, 2'b10, 0, 0);
    repeat (29 + 818) step(1, 2'b11, 0, 0);
    step(1, 2'b10, 0, 0);
    chk("pre_sat_total", total_score, 9998);
    chk("pre_sat_combo", combo, 255);
    step(1, 2'b11, 0, 0);
    chk("sat_total", total_score, 9999);
    wait_idle(40);
    chk("sat_bcd", score_bcd, 16'h9999);

    // back-to-back hits: busy held across the pending restart, no torn values
    step(0, 2'b00, 0, 1);
    for (int k = 0; k <= 32; k++) begin
      if (k < 3) step(1, 2'b11, 0, 0);
      else step(0, 2'b00, 0, 0);
      chk("b2b_busy", bcd_busy, int'(k < 32));
      if (k == 15) chk("b2b_bcd0", score_bcd, 16'h0000);
      if (k == 16) chk("b2b_bcd1", score_bcd, 16'h0003);
      if (k == 32) chk("b2b_bcd2", score_bcd, 16'h0009);
    end

    // game_start mid-conversion
    step(1, 2'b11, 0, 0);
    repeat (5) step(0, 2'b00, 0, 0);
    step(0, 2'b00, 0, 1);
    chk("abort_total", total_score, 0);
    chk("abort_bcd", score_bcd, 0);
    chk("abort_busy", bcd_busy, 0);
    chk("abort_flash", flash_on, 0);

    // asynchronous reset mid-flash
    step(1, 2'b11, 0, 0);
    repeat (2) step(0, 2'b00, 0, 0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_flash", flash_on, 0);
    chk("arst_total", total_score, 0);
    chk("arst_judge", judge_code, 0);
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bit dn, nm, gs;
      bit [1:0] sc;
      dn = ($urandom_range(0, 2) == 0);
      sc = 2'($urandom_range(0, 3));
      nm = ($urandom_range(0, 7) == 0);
      if (dn && sc == 2'b00) nm = 1'b0;
      gs = ($urandom_range(0, 299) == 0);
      step(dn, sc, nm, gs);
    end
    wait_idle(40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
